// File: rtl/control_pipe.sv
// Pipelined control-word carrier for a 5-stage MIPS-style core: ID/EX, EX/MEM and MEM/WB
// control registers with load-use stall detection and branch flush.
module control_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        inEnable,
  input  logic [11:0] inControl,
  input  logic [4:0]  inRs,
  input  logic [4:0]  inRt,
  input  logic [4:0]  inRd,
  input  logic        inBranchTaken,
  output logic        outRegDst,
  output logic [1:0]  outALUOp,
  output logic        outALUSrc,
  output logic        outBranch,
  output logic        outMemRead,
  output logic        outMemWrite,
  output logic [2:0]  outMemSize,
  output logic        outRegWrite,
  output logic        outMemtoReg,
  output logic [4:0]  outWriteReg,
  output logic        outStall,
  output logic        outFlush
);

  localparam int CTRL_W = 12;
  localparam int REG_W  = 5;

  logic [CTRL_W-1:0] ctrl_p0;
  logic [REG_W-1:0]  rt_p0;
  logic [REG_W-1:0]  rd_p0;
  logic [7:0]        ctrl_p1;
  logic [REG_W-1:0]  dest_p1;
  logic [1:0]        ctrl_p2;
  logic [REG_W-1:0]  dest_p2;

  logic              load_use;
  logic [REG_W-1:0]  dest_ex;
  logic              bubble_p0;

  always_comb begin
    load_use  = ctrl_p0[6] && (rt_p0 != '0) && ((rt_p0 == inRs) || (rt_p0 == inRt));
    dest_ex   = ctrl_p0[11] ? rd_p0 : rt_p0;
    // a taken branch squashes the dependent word anyway, so it never needs a stall
    bubble_p0 = inBranchTaken || load_use;
  end

  assign outStall = load_use && !inBranchTaken;
  assign outFlush = inBranchTaken;

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_p0 <= '0;
      rt_p0   <= '0;
      rd_p0   <= '0;
    end else if (inEnable) begin
      if (bubble_p0) begin
        ctrl_p0 <= '0;
        rt_p0   <= '0;
        rd_p0   <= '0;
      end else begin
        ctrl_p0 <= inControl;
        rt_p0   <= inRt;
        rd_p0   <= inRd;
      end
    end
  end

  // EX -> MEM boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_p1 <= '0;
      dest_p1 <= '0;
    end else if (inEnable) begin
      if (inBranchTaken) begin
        ctrl_p1 <= '0;
        dest_p1 <= '0;
      end else begin
        ctrl_p1 <= ctrl_p0[7:0];
        dest_p1 <= dest_ex;
      end
    end
  end

  // MEM -> WB boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_p2 <= '0;
      dest_p2 <= '0;
    end else if (inEnable) begin
      ctrl_p2 <= ctrl_p1[1:0];
      dest_p2 <= dest_p1;
    end
  end

  assign outRegDst   = ctrl_p0[11];
  assign outALUOp    = ctrl_p0[10:9];
  assign outALUSrc   = ctrl_p0[8];
  assign outBranch   = ctrl_p1[7];
  assign outMemRead  = ctrl_p1[6];
  assign outMemWrite = ctrl_p1[5];
  assign outMemSize  = ctrl_p1[4:2];
  assign outRegWrite = ctrl_p2[1];
  assign outMemtoReg = ctrl_p2[0];
  assign outWriteReg = dest_p2;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: directed vector table, reset corner sequence, and random
// traffic checked against an instruction-slot reference model.
module tb_control_pipe;

  logic        clk;
  logic        rst;
  logic        inEnable;
  logic [11:0] inControl;
  logic [4:0]  inRs, inRt, inRd;
  logic        inBranchTaken;
  logic        outRegDst;
  logic [1:0]  outALUOp;
  logic        outALUSrc;
  logic        outBranch, outMemRead, outMemWrite;
  logic [2:0]  outMemSize;
  logic        outRegWrite, outMemtoReg;
  logic [4:0]  outWriteReg;
  logic        outStall, outFlush;

  int n_vec = 0;
  int n_bad = 0;

  control_pipe dut (
    .clk(clk), .rst(rst), .inEnable(inEnable), .inControl(inControl),
    .inRs(inRs), .inRt(inRt), .inRd(inRd), .inBranchTaken(inBranchTaken),
    .outRegDst(outRegDst), .outALUOp(outALUOp), .outALUSrc(outALUSrc),
    .outBranch(outBranch), .outMemRead(outMemRead), .outMemWrite(outMemWrite),
    .outMemSize(outMemSize), .outRegWrite(outRegWrite), .outMemtoReg(outMemtoReg),
    .outWriteReg(outWriteReg), .outStall(outStall), .outFlush(outFlush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [11:0] c;
    logic [4:0]  rs, rt, rd;
    logic        br;
    logic        stall, flush;
    logic [3:0]  ex;
    logic [5:0]  mem;
    logic [6:0]  wb;
  } vec_t;

  // one instruction in flight: full control word plus its register fields
  typedef struct packed {
    logic [11:0] c;
    logic [4:0]  rt, rd, dest;
  } slot_t;

  slot_t m_ex, m_mem, m_wb;
  vec_t  tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] ex, input logic [5:0] mem,
                          input logic [6:0] wb);
    chk({tag, ".ex"},  {28'd0, outRegDst, outALUOp, outALUSrc}, {28'd0, ex});
    chk({tag, ".mem"}, {26'd0, outBranch, outMemRead, outMemWrite, outMemSize}, {26'd0, mem});
    chk({tag, ".wb"},  {25'd0, outRegWrite, outMemtoReg, outWriteReg}, {25'd0, wb});
  endtask

  task automatic drive(input logic en, input logic [11:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic br);
    inEnable = en; inControl = c; inRs = rs; inRt = rt; inRd = rd; inBranchTaken = br;
  endtask

  function automatic logic is_load(input slot_t s);
    return s.c[6];
  endfunction

  function automatic logic model_stall(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic br);
    return is_load(m_ex) && m_ex.rt != 0 && (m_ex.rt == rs || m_ex.rt == rt) && !br;
  endfunction

  task automatic model_step(input logic en, input logic [11:0] c, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic br);
    slot_t nw;
    logic  st;
    if (!en) return;
    st    = model_stall(rs, rt, br);
    m_wb  = m_mem;
    if (br) m_mem = '0;
    else begin
      m_mem      = m_ex;
      m_mem.dest = m_ex.c[11] ? m_ex.rd : m_ex.rt;
    end
    nw = '{c: c, rt: rt, rd: rd, dest: 5'd0};
    m_ex = (br || st) ? slot_t'('0) : nw;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_ex = '0; m_mem = '0; m_wb = '0;
  endtask

  initial begin
    logic [11:0] words [6];
    rst = 1'b0;
    drive(1'b0, 12'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    chk_outs("reset_async", 4'h0, 6'h00, 7'h00);
    repeat (2) @(negedge clk);
    chk_outs("reset_held", 4'h0, 6'h00, 7'h00);
    rst = 1'b1;

    //          en  ctrl    rs  rt  rd br  stl fl  ex    mem    wb
    tbl[0]  = '{1'b1, 12'hC02, 5'd1, 5'd7, 5'd5, 1'b0, 1'b0, 1'b0, 4'hC, 6'h00, 7'h00};
    tbl[1]  = '{1'b1, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'h0, 6'h00, 7'h00};
    tbl[2]  = '{1'b1, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'h0, 6'h00, 7'h45};
    tbl[3]  = '{1'b1, 12'h143, 5'd0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 4'h1, 6'h00, 7'h00};
    tbl[4]  = '{1'b1, 12'hC02, 5'd8, 5'd3, 5'd9, 1'b0, 1'b1, 1'b0, 4'h0, 6'h10, 7'h00};
    tbl[5]  = '{1'b1, 12'hC02, 5'd8, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 4'hC, 6'h00, 7'h68};
    tbl[6]  = '{1'b1, 12'h280, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0, 4'h2, 6'h00, 7'h00};
    tbl[7]  = '{1'b1, 12'h143, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 4'h1, 6'h20, 7'h49};
    tbl[8]  = '{1'b1, 12'hC02, 5'd4, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 4'h0, 6'h00, 7'h02};
    tbl[9]  = '{1'b1, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'h0, 6'h00, 7'h00};
    tbl[10] = '{1'b1, 12'h143, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 4'h1, 6'h00, 7'h00};
    tbl[11] = '{1'b0, 12'hC02, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 4'h1, 6'h00, 7'h00};
    tbl[12] = '{1'b0, 12'hC02, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0, 4'h1, 6'h00, 7'h00};
    tbl[13] = '{1'b0, 12'hC02, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 4'h1, 6'h00, 7'h00};

    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].c, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].br);
      #1;
      chk($sformatf("tbl%0d.stall", i), {31'd0, outStall}, {31'd0, tbl[i].stall});
      chk($sformatf("tbl%0d.flush", i), {31'd0, outFlush}, {31'd0, tbl[i].flush});
      @(posedge clk);
      #1;
      chk_outs($sformatf("tbl%0d", i), tbl[i].ex, tbl[i].mem, tbl[i].wb);
      @(negedge clk);
    end

    // asynchronous reset while a load sits in MEM
    apply_reset();
    drive(1'b1, 12'h143, 5'd0, 5'd8, 5'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("lw_in_mem.memread", {31'd0, outMemRead}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid.memread",  {31'd0, outMemRead}, 32'd0);
    chk("rst_mid.regwrite", {31'd0, outRegWrite}, 32'd0);
    chk("rst_mid.writereg", {27'd0, outWriteReg}, 32'd0);
    drive(1'b1, 12'hC02, 5'd0, 5'd7, 5'd5, 1'b0);
    @(posedge clk);
    #1;
    chk_outs("rst_over_edge", 4'h0, 6'h00, 7'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_outs("post_rst_first", 4'hC, 6'h00, 7'h00);
    drive(1'b1, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_outs("post_rst_wb", 4'h0, 6'h00, 7'h45);

    // random traffic against the slot model
    apply_reset();
    words[0] = 12'h000; words[1] = 12'hC02; words[2] = 12'h143;
    words[3] = 12'h280; words[4] = 12'h12C; words[5] = 12'hC03;
    for (int k = 0; k < 400; k++) begin
      logic        en, br;
      logic [11:0] c;
      logic [4:0]  rs, rt, rd;
      en = ($urandom_range(0, 9) < 8);
      br = ($urandom_range(0, 9) < 1);
      c  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : words[$urandom_range(0, 5)];
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 31));
      drive(en, c, rs, rt, rd, br);
      #1;
      chk("rnd.stall", {31'd0, outStall}, {31'd0, model_stall(rs, rt, br)});
      chk("rnd.flush", {31'd0, outFlush}, {31'd0, br});
      @(posedge clk);
      #1;
      model_step(en, c, rs, rt, rd, br);
      chk_outs("rnd", m_ex.c[11:8], m_mem.c[7:2], {m_wb.c[1:0], m_wb.dest});
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
